// File: rtl/imem_resp_if.sv
// Request/response bundle between a fetch-stage requester and the
// multi-cycle memory responder.
interface imem_resp_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  modport master (output addr, data_in, rd, wr, input data_out, stall, done, err);
  modport slave  (input addr, data_in, rd, wr, output data_out, stall, done, err);
endinterface

// File: rtl/imem_resp.sv
// Multi-cycle memory responder: one request in flight, stall while busy,
// one-cycle done pulse with read data / error status after LATENCY cycles.
module imem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  imem_resp_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [15:0]           req_addr, req_data;
  logic                  req_rd, req_wr;
  logic [15:0]           mem [DEPTH];
  logic                  accept, complete, mem_we;
  logic [15:0]           cur_addr, cur_data;
  logic                  cur_rd, cur_wr, cur_err;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  done_q, err_q;
  logic [15:0]           data_q;

  assign accept = (bus.rd | bus.wr) & (state == IDLE);

  // With LATENCY=1 the request completes at its own acceptance edge, so the
  // live inputs are the request; otherwise use the latched copy.
  assign cur_addr = (state == IDLE) ? bus.addr    : req_addr;
  assign cur_data = (state == IDLE) ? bus.data_in : req_data;
  assign cur_rd   = (state == IDLE) ? bus.rd      : req_rd;
  assign cur_wr   = (state == IDLE) ? bus.wr      : req_wr;
  assign cur_err  = cur_addr[0] | ({1'b0, cur_addr[15:1]} >= 16'(DEPTH)) | (cur_rd & cur_wr);
  assign idx      = cur_addr[DEPTH_LOG2:1];
  assign mem_we   = complete & cur_wr & ~cur_err & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            complete = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr <= '0;
      req_data <= '0;
      req_rd   <= 1'b0;
      req_wr   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      if (accept) begin
        req_addr <= bus.addr;
        req_data <= bus.data_in;
        req_rd   <= bus.rd;
        req_wr   <= bus.wr;
      end
      done_q <= complete;
      err_q  <= complete & cur_err;
      if (complete && cur_err)
        data_q <= '0;
      else if (complete && cur_rd)
        data_q <= mem[idx];
    end
  end

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk)
    if (mem_we) mem[idx] <= cur_data;

  assign bus.stall    = (state == BUSY);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_imem_resp.sv
// Bench: five responders (LATENCY 1..5) share one randomized request stream;
// a transaction-level model per instance predicts every output each cycle.
module tb_imem_resp;
  localparam int N = 5;
  localparam int LATS [N] = '{1, 2, 3, 4, 5};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, din;
  logic        rd, wr;

  logic        done_v  [N];
  logic        stall_v [N];
  logic        err_v   [N];
  logic [15:0] dout_v  [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g
    imem_resp_if bus ();
    assign bus.addr    = addr;
    assign bus.data_in = din;
    assign bus.rd      = rd;
    assign bus.wr      = wr;
    assign done_v[gi]  = bus.done;
    assign stall_v[gi] = bus.stall;
    assign err_v[gi]   = bus.err;
    assign dout_v[gi]  = bus.data_out;
    imem_resp #(.DEPTH_LOG2(10), .LATENCY(LATS[gi])) dut (.clk(clk), .rst(rst), .bus(bus));
  end

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: one pending request per instance with the cycle it must finish in.
  bit          pend   [N];
  int          due    [N];
  bit          prd    [N], pwr [N], perr [N];
  int          pkey   [N];
  logic [15:0] pdat   [N];
  logic [15:0] edout  [N];
  bit          dknown [N];
  logic [15:0] mm [int];
  bit          l1_stall_seen = 0;
  bit          sw_on = 0;
  int          done_cnt [N];
  bit          ed, es;

  initial for (int i = 0; i < N; i++) begin
    pend[i] = 0; edout[i] = 0; dknown[i] = 1; done_cnt[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      ed = 0;
      es = 0;
      if (rst) begin
        // a write whose done cycle was cut short by reset already hit the array
        if (pend[i] && due[i] <= cyc && pwr[i] && !perr[i]) mm[i*65536 + pkey[i]] = pdat[i];
        pend[i] = 0; edout[i] = 16'h0000; dknown[i] = 1;
      end else begin
        ed = pend[i] && (due[i] == cyc);
        es = pend[i] && (due[i] > cyc);
        if (ed) begin
          pend[i] = 0;
          if (perr[i]) begin
            edout[i] = 16'h0000; dknown[i] = 1;
          end else if (prd[i]) begin
            dknown[i] = mm.exists(i*65536 + pkey[i]);
            if (dknown[i]) edout[i] = mm[i*65536 + pkey[i]];
          end else begin
            mm[i*65536 + pkey[i]] = pdat[i];
          end
        end
      end
      chk($sformatf("done[L%0d]", LATS[i]), 16'(done_v[i]), 16'(ed));
      chk($sformatf("stall[L%0d]", LATS[i]), 16'(stall_v[i]), 16'(es));
      if (ed || rst) chk($sformatf("err[L%0d]", LATS[i]), 16'(err_v[i]), 16'(ed && perr[i]));
      if (dknown[i]) chk($sformatf("data_out[L%0d]", LATS[i]), dout_v[i], edout[i]);
      if (i == 0 && stall_v[i]) l1_stall_seen = 1;
      if (sw_on && done_v[i]) done_cnt[i]++;
      if (!rst && !es && (rd || wr)) begin
        pend[i] = 1;
        due[i]  = cyc + LATS[i];
        prd[i]  = rd;
        pwr[i]  = wr;
        pkey[i] = int'(addr >> 1);
        pdat[i] = din;
        perr[i] = addr[0] || (int'(addr >> 1) >= 1024) || (rd && wr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        r_done [N];
  logic        r_err  [N];
  logic [15:0] r_dout [N];

  // Present one request for one cycle with every instance idle and record
  // each instance's outputs in its own done cycle.
  task automatic xact(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    tick();
    rd = r; wr = w; addr = a; din = d;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) begin rd = 0; wr = 0; end
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (j == LATS[i]) begin
          r_done[i] = done_v[i]; r_err[i] = err_v[i]; r_dout[i] = dout_v[i];
        end
    end
  endtask

  initial begin
    int op, k;
    logic [15:0] a;
    rst = 1; rd = 0; wr = 0; addr = 0; din = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_stall", 16'(stall_v[i]), 16'h0);
      chk("rst_done",  16'(done_v[i]),  16'h0);
      chk("rst_dout",  dout_v[i],       16'h0000);
    end
    @(posedge clk);
    #2 rst = 0;

    // Write then read-in-done-cycle on the LATENCY=2 instance.
    tick(); wr = 1; addr = 16'h0010; din = 16'hBEEF;
    tick(); wr = 0; @(negedge clk); chk("wr_stall_c1", 16'(stall_v[1]), 16'h1);
    tick(); rd = 1; addr = 16'h0010; @(negedge clk);
    chk("wr_done_c2", 16'(done_v[1]), 16'h1);
    chk("wr_err_c2",  16'(err_v[1]),  16'h0);
    tick(); rd = 0; @(negedge clk); chk("rd_nodone_c3", 16'(done_v[1]), 16'h0);
    tick(); @(negedge clk);
    chk("rd_done_c4", 16'(done_v[1]), 16'h1);
    chk("rd_data_c4", dout_v[1], 16'hBEEF);
    tick(); @(negedge clk);
    chk("rd_hold", dout_v[1], 16'hBEEF);
    repeat (6) tick();

    // Stall ignore: read held from the stalled cycle into the done cycle.
    tick(); wr = 1; addr = 16'h0002; din = 16'h5A5A;
    tick(); wr = 0; rd = 1; @(negedge clk);
    chk("si_stall_c1", 16'(stall_v[1]), 16'h1);
    chk("si_nodone_c1", 16'(done_v[1]), 16'h0);
    tick(); @(negedge clk); chk("si_done_c2", 16'(done_v[1]), 16'h1);
    tick(); rd = 0; @(negedge clk); chk("si_nodone_c3", 16'(done_v[1]), 16'h0);
    tick(); @(negedge clk);
    chk("si_done_c4", 16'(done_v[1]), 16'h1);
    chk("si_data_c4", dout_v[1], 16'h5A5A);
    repeat (6) tick();

    // Error classes.
    xact(0, 1, 16'h0000, 16'h1111);
    xact(1, 0, 16'h0011, 16'h0000);
    chk("mis_done", 16'(r_done[1]), 16'h1);
    chk("mis_err",  16'(r_err[1]),  16'h1);
    chk("mis_dout", r_dout[1],      16'h0000);
    xact(0, 1, 16'h0800, 16'h2222);
    chk("oor_err", 16'(r_err[1]), 16'h1);
    xact(1, 0, 16'h0000, 16'h0000);
    chk("oor_w0", r_dout[1], 16'h1111);
    xact(1, 1, 16'h0000, 16'h3333);
    chk("rdwr_err",  16'(r_err[1]), 16'h1);
    chk("rdwr_dout", r_dout[1],     16'h0000);
    xact(1, 0, 16'h0000, 16'h0000);
    chk("rdwr_nowr", r_dout[1], 16'h1111);

    // Reset mid-request on the LATENCY=4 instance.
    xact(0, 1, 16'h0020, 16'h7777);
    tick(); wr = 1; addr = 16'h0020; din = 16'h1234;
    tick(); wr = 0;
    tick();
    #2 rst = 1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("arst_stall", 16'(stall_v[i]), 16'h0);
      chk("arst_done",  16'(done_v[i]),  16'h0);
      chk("arst_err",   16'(err_v[i]),   16'h0);
      chk("arst_dout",  dout_v[i],       16'h0000);
    end
    tick(); #1 rst = 0;
    for (int j = 0; j < 6; j++) begin
      tick(); @(negedge clk); chk("arst_nodone_l4", 16'(done_v[3]), 16'h0);
    end
    xact(1, 0, 16'h0020, 16'h0000);
    chk("arst_keep_l4", r_dout[3], 16'h7777);
    chk("arst_wrote_l2", r_dout[1], 16'h1234);

    // Seed words 0..15 so random reads have known contents.
    for (int w = 0; w < 16; w++) xact(0, 1, 16'(w * 2), 16'($urandom));

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 900; n++) begin
      tick();
      rst = ($urandom_range(0, 249) == 0);
      op  = int'($urandom_range(0, 9));
      k   = int'($urandom_range(0, 9));
      if (k < 8)       a = 16'($urandom_range(0, 15) * 2);
      else if (k == 8) a = 16'($urandom_range(0, 15) * 2 + 1);
      else             a = 16'h0800 | 16'($urandom_range(0, 1023) * 2);
      addr = a;
      din  = 16'($urandom);
      rd   = (op <= 3) || (op == 7);
      wr   = (op >= 4 && op <= 7);
    end
    tick(); rst = 0; rd = 0; wr = 0;
    repeat (6) tick();

    // Back-to-back reads held for 45 cycles.
    tick(); sw_on = 1;
    for (int s = 0; s < 45; s++) begin
      rd = 1; wr = 0; addr = 16'(2 * (s % 16));
      if (s < 44) tick();
    end
    tick(); rd = 0;
    repeat (6) tick();
    sw_on = 0;
    for (int i = 0; i < N; i++)
      chk($sformatf("sweep_dones[L%0d]", LATS[i]), 16'(done_cnt[i]), 16'(44 / LATS[i] + 1));
    chk("l1_never_stall", 16'(l1_stall_seen), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
